// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings and a
// constant-foldable ceil(log2) helper used to size the shift-amount port.
package shift_pkg;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v      = value - 1;
        while (v != 0) begin
            v      = v >> 1;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage of the barrel shifter: a contiguous group of right-shift
// mux levels followed by the stage register with its valid/ready handshake.
module shift_stage
    import shift_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned TAG_WIDTH   = 5,
    parameter int unsigned SHAMT_WIDTH = 5,
    parameter int unsigned FIRST_LEVEL = 0,
    parameter int unsigned NUM_LEVELS  = 1,
    parameter bit          LAST_STAGE  = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [1:0]             in_op,
    input  logic [SHAMT_WIDTH-1:0] in_shamt,
    input  logic                   in_fill,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [1:0]             out_op,
    output logic [SHAMT_WIDTH-1:0] out_shamt,
    output logic                   out_fill,
    output logic [TAG_WIDTH-1:0]   out_tag
);

    localparam logic [DATA_WIDTH-1:0] ONES = '1;

    logic                   valid_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [1:0]             op_q;
    logic [SHAMT_WIDTH-1:0] shamt_q;
    logic                   fill_q;
    logic [TAG_WIDTH-1:0]   tag_q;

    logic [DATA_WIDTH-1:0]  shifted;
    logic [DATA_WIDTH-1:0]  result;
    logic                   load;

    assign in_ready = ~valid_q | out_ready;
    assign load     = in_valid & in_ready & ~flush;

    // Level k moves the word right by 2^k; fill is zero for SLL/SRL and the
    // captured sign for SRA, while ROTR wraps the low bits round to the top.
    always_comb begin
        shifted = in_data;
        for (int k = 0; k < NUM_LEVELS; k++) begin
            if (in_shamt[FIRST_LEVEL + k]) begin
                if (in_op == OP_ROTR) begin
                    shifted = (shifted >> (1 << (FIRST_LEVEL + k)))
                            | (shifted << (DATA_WIDTH - (1 << (FIRST_LEVEL + k))));
                end else begin
                    shifted = (shifted >> (1 << (FIRST_LEVEL + k)))
                            | ({DATA_WIDTH{in_fill}} & ~(ONES >> (1 << (FIRST_LEVEL + k))));
                end
            end
        end
        result = shifted;
        if (LAST_STAGE && (in_op == OP_SLL)) begin
            for (int b = 0; b < DATA_WIDTH; b++) begin
                result[b] = shifted[DATA_WIDTH-1-b];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            op_q    <= '0;
            shamt_q <= '0;
            fill_q  <= 1'b0;
            tag_q   <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (in_ready) begin
                valid_q <= in_valid;
            end
            if (load) begin
                data_q  <= result;
                op_q    <= in_op;
                shamt_q <= in_shamt;
                fill_q  <= in_fill;
                tag_q   <= in_tag;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_op    = op_q;
    assign out_shamt = shamt_q;
    assign out_fill  = fill_q;
    assign out_tag   = tag_q;

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined SLL/SRL/SRA/ROTR barrel shifter with valid/ready flow control,
// flush and a tag that rides alongside each operand.
module shift_unit_pipe
    import shift_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned TAG_WIDTH   = 5,
    localparam int unsigned SHAMT_WIDTH = clog2(DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [SHAMT_WIDTH-1:0] in_shamt,
    input  logic [1:0]             in_op,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [TAG_WIDTH-1:0]   out_tag
);

    localparam int unsigned LEVELS_PER_STAGE = (SHAMT_WIDTH + PIPE_STAGES - 1) / PIPE_STAGES;

    // Index i is the boundary feeding stage i; index PIPE_STAGES is the output.
    logic                   stg_valid [PIPE_STAGES+1];
    logic                   stg_ready [PIPE_STAGES+1];
    logic [DATA_WIDTH-1:0]  stg_data  [PIPE_STAGES+1];
    logic [1:0]             stg_op    [PIPE_STAGES+1];
    logic [SHAMT_WIDTH-1:0] stg_shamt [PIPE_STAGES+1];
    logic                   stg_fill  [PIPE_STAGES+1];
    logic [TAG_WIDTH-1:0]   stg_tag   [PIPE_STAGES+1];

    logic [DATA_WIDTH-1:0]  entry_data;

    // SLL is done as a right shift of the bit-reversed operand.
    always_comb begin
        entry_data = in_data;
        if (in_op == OP_SLL) begin
            for (int b = 0; b < DATA_WIDTH; b++) begin
                entry_data[b] = in_data[DATA_WIDTH-1-b];
            end
        end
    end

    assign stg_valid[0] = in_valid;
    assign stg_data[0]  = entry_data;
    assign stg_op[0]    = in_op;
    assign stg_shamt[0] = in_shamt;
    assign stg_fill[0]  = (in_op == OP_SRA) & in_data[DATA_WIDTH-1];
    assign stg_tag[0]   = in_tag;

    assign stg_ready[PIPE_STAGES] = out_ready;
    assign in_ready  = stg_ready[0] & ~flush;
    assign out_valid = stg_valid[PIPE_STAGES];
    assign out_data  = stg_data[PIPE_STAGES];
    assign out_tag   = stg_tag[PIPE_STAGES];

    for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
        localparam int unsigned FIRST_RAW = LEVELS_PER_STAGE * i;
        localparam int unsigned COUNT =
            (FIRST_RAW >= SHAMT_WIDTH) ? 0 :
            ((SHAMT_WIDTH - FIRST_RAW < LEVELS_PER_STAGE) ? SHAMT_WIDTH - FIRST_RAW
                                                          : LEVELS_PER_STAGE);
        // Stages left without levels keep a legal base index; they only delay.
        localparam int unsigned FIRST = (COUNT == 0) ? 0 : FIRST_RAW;

        shift_stage #(
            .DATA_WIDTH  (DATA_WIDTH),
            .TAG_WIDTH   (TAG_WIDTH),
            .SHAMT_WIDTH (SHAMT_WIDTH),
            .FIRST_LEVEL (FIRST),
            .NUM_LEVELS  (COUNT),
            .LAST_STAGE  (i == PIPE_STAGES - 1)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .in_valid  (stg_valid[i]),
            .in_ready  (stg_ready[i]),
            .in_data   (stg_data[i]),
            .in_op     (stg_op[i]),
            .in_shamt  (stg_shamt[i]),
            .in_fill   (stg_fill[i]),
            .in_tag    (stg_tag[i]),
            .out_valid (stg_valid[i+1]),
            .out_ready (stg_ready[i+1]),
            .out_data  (stg_data[i+1]),
            .out_op    (stg_op[i+1]),
            .out_shamt (stg_shamt[i+1]),
            .out_fill  (stg_fill[i+1]),
            .out_tag   (stg_tag[i+1])
        );
    end

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Scoreboard bench for shift_unit_pipe: default 32-bit/2-stage instance plus
// 16-bit instances with one and four stages.
module tb_shift_unit_pipe;
    import shift_pkg::*;

    localparam int PIPE = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [4:0]  in_shamt, in_tag, out_tag;
    logic [1:0]  in_op;

    logic        s_valid, ready1, ready4, ov1, ov4;
    logic [15:0] s_data, od1, od4;
    logic [3:0]  s_shamt;
    logic [1:0]  s_op;
    logic [4:0]  s_tag, ot1, ot4;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n;
    bit          stall_prev = 1'b0;
    logic [31:0] prev_data;
    logic [4:0]  prev_tag;

    shift_unit_pipe #(.DATA_WIDTH(32), .PIPE_STAGES(2), .TAG_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
    );

    shift_unit_pipe #(.DATA_WIDTH(16), .PIPE_STAGES(1), .TAG_WIDTH(5)) dut_p1 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(s_valid), .in_ready(ready1), .in_data(s_data),
        .in_shamt(s_shamt), .in_op(s_op), .in_tag(s_tag),
        .out_valid(ov1), .out_ready(1'b1), .out_data(od1), .out_tag(ot1)
    );

    shift_unit_pipe #(.DATA_WIDTH(16), .PIPE_STAGES(4), .TAG_WIDTH(5)) dut_p4 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(s_valid), .in_ready(ready4), .in_data(s_data),
        .in_shamt(s_shamt), .in_op(s_op), .in_tag(s_tag),
        .out_valid(ov4), .out_ready(1'b1), .out_data(od4), .out_tag(ot4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish by time limit, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model32(logic [31:0] d, logic [4:0] s, logic [1:0] op);
        case (op)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return $signed(d) >>> s;
            default: return (d >> s) | (d << (6'd32 - {1'b0, s}));
        endcase
    endfunction

    function automatic logic [15:0] model16(logic [15:0] d, logic [3:0] s, logic [1:0] op);
        case (op)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return $signed(d) >>> s;
            default: return (d >> s) | (d << (5'd16 - {1'b0, s}));
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op,
                            input logic [4:0] tag, input bit lat);
        exp_t e;
        e.data = model32(d, s, op);
        e.tag  = tag;
        e.acc  = cyc + 1;
        e.lat  = lat;
        exp_q.push_back(e);
    endtask

    // Entered and left just after a rising edge; holds in_valid high on return.
    task automatic send(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op,
                        input logic [4:0] tag, input bit lat);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_op    = op;
        in_tag   = tag;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                push_exp(d, s, op, tag, lat);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) check("send_timeout", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic run16(input logic [15:0] d, input logic [3:0] s, input logic [1:0] op,
                         input logic [4:0] tag);
        logic [15:0] want;
        int          lat1, lat4;
        want    = model16(d, s, op);
        lat1    = 0;
        lat4    = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_shamt = s;
        s_op    = op;
        s_tag   = tag;
        @(negedge clk);
        check("p1_in_ready", {63'd0, ready1}, 64'd1);
        check("p4_in_ready", {63'd0, ready4}, 64'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (ov1 && lat1 == 0) begin
                lat1 = c;
                check("p1_data", od1, want);
                check("p1_tag", ot1, tag);
            end
            if (ov4 && lat4 == 0) begin
                lat4 = c;
                check("p4_data", od4, want);
                check("p4_tag", ot4, tag);
            end
        end
        check("p1_latency", lat1, 1);
        check("p4_latency", lat4, 4);
        @(posedge clk); #1;
    endtask

    // Output side of the scoreboard; a handshake is decided by values held
    // stable from this falling edge to the next rising edge.
    always @(negedge clk) begin
        if (rst_n && !flush) begin
            if (stall_prev) begin
                check("stall_valid", {63'd0, out_valid}, 64'd1);
                check("stall_data", out_data, prev_data);
                check("stall_tag", out_tag, prev_tag);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", {63'd0, out_valid}, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", out_data, mon_e.data);
                    check("out_tag", out_tag, mon_e.tag);
                    if (mon_e.lat) check("latency", cyc + 1 - mon_e.acc, PIPE);
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_tag   = out_tag;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        s_valid   = 1'b0;
        s_data    = '0;
        s_shamt   = '0;
        s_op      = '0;
        s_tag     = '0;

        #1 rst_n = 1'b0;
        #1;
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_out_data", out_data, 0);
        check("reset_out_tag", out_tag, 0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready", {63'd0, in_ready}, 64'd1);

        // Directed ops, back to back with no stall.
        send(32'h0000_0001, 5'd2,  OP_SLL,  5'd1, 1'b1);
        send(32'hFFFF_FFFF, 5'd31, OP_SLL,  5'd2, 1'b1);
        send(32'h8000_0000, 5'd4,  OP_SRA,  5'd3, 1'b1);
        send(32'h8000_0000, 5'd4,  OP_SRL,  5'd4, 1'b1);
        send(32'h0000_00F1, 5'd4,  OP_ROTR, 5'd5, 1'b1);
        send(32'h8000_0000, 5'd31, OP_SRA,  5'd6, 1'b1);
        for (int op = 0; op < 4; op++) send(32'hDEAD_BEEF, 5'd0, 2'(op), 5'(10 + op), 1'b1);
        drain();

        for (int i = 0; i < 12; i++) begin
            send($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 5'(i), 1'b1);
        end
        drain();

        // Six-item stream with the sink stalled in cycles 3..5.
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (n >= 6 && exp_q.size() == 0) break;
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (n < 6);
            if (n < 6) begin
                in_data  = $urandom;
                in_shamt = 5'($urandom_range(0, 31));
                in_op    = 2'($urandom_range(0, 3));
                in_tag   = 5'(n + 1);
            end
            @(negedge clk);
            if (in_valid) begin
                check("stream_in_ready", {63'd0, in_ready},
                      {63'd0, (exp_q.size() < PIPE) || out_ready});
                if (in_ready) begin
                    push_exp(in_data, in_shamt, in_op, in_tag, 1'b0);
                    n++;
                end
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_drained", exp_q.size(), 0);

        // Flush with two items in flight and a new operand waiting.
        send(32'h1234_5678, 5'd3, OP_SRL, 5'd7, 1'b0);
        send(32'h8765_4321, 5'd9, OP_SRA, 5'd8, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'hCAFE_F00D;
        in_shamt = 5'd8;
        in_op    = OP_ROTR;
        in_tag   = 5'd9;
        flush    = 1'b1;
        @(negedge clk);
        check("flush_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        exp_q.delete();
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        send(32'hCAFE_F00D, 5'd8, OP_ROTR, 5'd9, 1'b1);
        drain();

        // Asynchronous reset between edges with results in flight.
        send(32'hDEAD_BEEF, 5'd0, OP_SRL,  5'd10, 1'b0);
        send(32'h0F0F_0000, 5'd4, OP_ROTR, 5'd11, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("async_rst_out_data", out_data, 0);
        check("async_rst_out_tag", out_tag, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (5) @(posedge clk);
        #1;
        check("post_reset_out_valid", {63'd0, out_valid}, 64'd0);

        // 16-bit instances, one and four stages.
        run16(16'h0001, 4'd2,  OP_SLL,  5'd1);
        run16(16'hFFFF, 4'd15, OP_SLL,  5'd2);
        run16(16'h8000, 4'd4,  OP_SRA,  5'd3);
        run16(16'h00F1, 4'd4,  OP_ROTR, 5'd4);
        run16(16'hBEEF, 4'd0,  OP_SRA,  5'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
